// File: rtl/mod_settings_loader.sv
// Modulation settings loader: polls the controller flag word and, on a rising
// mod-set flag, burst-reads 0x20..0x30 and publishes one consistent bundle.
`timescale 1ns/1ps
module mod_settings_loader #(
   parameter int READ_LATENCY  = 2,
   parameter int POLL_INTERVAL = 16
) (
   input  logic        CLK,
   input  logic        RST_N,
   output logic [7:0]  CTL_BRAM_ADDR,
   output logic        CTL_BRAM_EN,
   input  logic [15:0] CTL_BRAM_DOUT,
   output logic        MEM_WR_SEGMENT,
   output logic        REQ_RD_SEGMENT,
   output logic [15:0] CYCLE0,
   output logic [15:0] CYCLE1,
   output logic [31:0] FREQ_DIV0,
   output logic [31:0] FREQ_DIV1,
   output logic [31:0] REP0,
   output logic [31:0] REP1,
   output logic [7:0]  TRANSITION_MODE,
   output logic [63:0] TRANSITION_VALUE,
   output logic        UPDATE,
   output logic        BUSY
);

   typedef enum logic [2:0] {
      S_WAIT, S_FLAG_REQ, S_FLAG_WAIT, S_CHECK, S_LOAD, S_DRAIN
   } state_t;

   localparam int NREG = 17;

   state_t            state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic [4:0]        idx_q, idx_d;
   logic              flag_q, flag_d;
   logic              prev_q, prev_d;
   logic              issue;
   logic              last_cap;
   logic [READ_LATENCY-1:0] pv_q;
   logic [4:0]        pi_q [READ_LATENCY];
   logic [15:0]       sh_q [NREG];
   logic [15:0]       sh_d [NREG];

   logic        mws_q, rrs_q;
   logic [15:0] c0_q, c1_q;
   logic [31:0] fd0_q, fd1_q, r0_q, r1_q;
   logic [7:0]  tm_q;
   logic [63:0] tv_q;
   logic        upd_q;
   logic        unused_bits;

   // Poll/load sequencer: next state, counters and read-port drive
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      idx_d         = idx_q;
      flag_d        = flag_q;
      prev_d        = prev_q;
      issue         = 1'b0;
      CTL_BRAM_EN   = 1'b0;
      CTL_BRAM_ADDR = 8'h00;
      unique case (state_q)
         S_WAIT: begin
            if (cnt_q == 16'(POLL_INTERVAL - 1)) begin
               cnt_d   = 16'd0;
               state_d = S_FLAG_REQ;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_FLAG_REQ: begin
            CTL_BRAM_EN = 1'b1;
            cnt_d       = 16'd0;
            state_d     = S_FLAG_WAIT;
         end
         S_FLAG_WAIT: begin
            if (cnt_q == 16'(READ_LATENCY - 1)) begin
               flag_d  = CTL_BRAM_DOUT[1];
               cnt_d   = 16'd0;
               state_d = S_CHECK;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_CHECK: begin
            prev_d = flag_q;
            cnt_d  = 16'd0;
            idx_d  = 5'd0;
            if (flag_q && !prev_q) state_d = S_LOAD;
            else                   state_d = S_WAIT;
         end
         S_LOAD: begin
            issue         = 1'b1;
            CTL_BRAM_EN   = 1'b1;
            CTL_BRAM_ADDR = 8'h20 + {3'b000, idx_q};
            if (idx_q == 5'd16) state_d = S_DRAIN;
            else                idx_d   = idx_q + 5'd1;
         end
         S_DRAIN: begin
            cnt_d = 16'd0;
            if (last_cap) state_d = S_WAIT;
         end
         default: state_d = S_WAIT;
      endcase
   end

   assign last_cap = pv_q[READ_LATENCY-1] &&
                     (pi_q[READ_LATENCY-1] == 5'd16);

   // Shadow next-state: merge the word returning this cycle
   always_comb begin
      sh_d = sh_q;
      for (int i = 0; i < NREG; i++) begin
         if (pv_q[READ_LATENCY-1] && (pi_q[READ_LATENCY-1] == 5'(i)))
            sh_d[i] = CTL_BRAM_DOUT;
      end
   end

   // Sequencer state, index pipeline and shadow storage
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_WAIT;
         cnt_q   <= 16'd0;
         idx_q   <= 5'd0;
         flag_q  <= 1'b0;
         prev_q  <= 1'b0;
         pv_q    <= '0;
         for (int i = 0; i < READ_LATENCY; i++) pi_q[i] <= 5'd0;
         for (int i = 0; i < NREG; i++) sh_q[i] <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         flag_q  <= flag_d;
         prev_q  <= prev_d;
         pv_q[0] <= issue;
         pi_q[0] <= idx_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pi_q[i] <= pi_q[i-1];
         end
         for (int i = 0; i < NREG; i++) sh_q[i] <= sh_d[i];
      end
   end

   // Publish the whole bundle at once when the final word lands
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         mws_q <= 1'b0;
         rrs_q <= 1'b0;
         c0_q  <= 16'd0;
         c1_q  <= 16'd0;
         fd0_q <= 32'd0;
         fd1_q <= 32'd0;
         r0_q  <= 32'hFFFF_FFFF;
         r1_q  <= 32'hFFFF_FFFF;
         tm_q  <= 8'd0;
         tv_q  <= 64'd0;
         upd_q <= 1'b0;
      end else begin
         upd_q <= last_cap;
         if (last_cap) begin
            mws_q <= sh_d[0][0];
            rrs_q <= sh_d[1][0];
            c0_q  <= sh_d[2];
            fd0_q <= {sh_d[4], sh_d[3]};
            c1_q  <= sh_d[5];
            fd1_q <= {sh_d[7], sh_d[6]};
            r0_q  <= {sh_d[9], sh_d[8]};
            r1_q  <= {sh_d[11], sh_d[10]};
            tm_q  <= sh_d[12][7:0];
            tv_q  <= {sh_d[16], sh_d[15], sh_d[14], sh_d[13]};
         end
      end
   end

   assign unused_bits = ^{sh_d[0][15:1], sh_d[1][15:1], sh_d[12][15:8]};

   assign MEM_WR_SEGMENT   = mws_q;
   assign REQ_RD_SEGMENT   = rrs_q;
   assign CYCLE0           = c0_q;
   assign CYCLE1           = c1_q;
   assign FREQ_DIV0        = fd0_q;
   assign FREQ_DIV1        = fd1_q;
   assign REP0             = r0_q;
   assign REP1             = r1_q;
   assign TRANSITION_MODE  = tm_q;
   assign TRANSITION_VALUE = tv_q;
   assign UPDATE           = upd_q;
   assign BUSY             = (state_q == S_LOAD) || (state_q == S_DRAIN);

endmodule

// File: tb/tb_mod_settings_loader.sv
// Bench for mod_settings_loader: three instances (latency 2, 1, 4) share one
// controller memory image; a monitor pops expected bundles on each UPDATE.
`timescale 1ns/1ps
module tb_mod_settings_loader;

   typedef struct packed {
      logic        mws;
      logic        rrs;
      logic [15:0] c0;
      logic [15:0] c1;
      logic [31:0] fd0;
      logic [31:0] fd1;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [7:0]  tm;
      logic [63:0] tv;
   } bundle_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_x = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] mem [256];

   logic [7:0]  addr [3];
   logic        en [3];
   logic [15:0] dout [3];
   logic        mws_o [3];
   logic        rrs_o [3];
   logic [15:0] c0_o [3];
   logic [15:0] c1_o [3];
   logic [31:0] fd0_o [3];
   logic [31:0] fd1_o [3];
   logic [31:0] r0_o [3];
   logic [31:0] r1_o [3];
   logic [7:0]  tm_o [3];
   logic [63:0] tv_o [3];
   logic        upd_o [3];
   logic        busy_o [3];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int iss [3];
   int upd_cnt [3];
   bundle_t cur [3];
   bundle_t expq [3][$];
   bundle_t rst_b;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      logic [15:0] pipe [LAT];
      logic        rst_g;
      assign rst_g = (g == 0) ? rst_n : rst_x;

      always @(posedge clk) begin
         if (en[g]) pipe[0] <= mem[addr[g]];
         for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign dout[g] = pipe[LAT-1];

      mod_settings_loader #(
         .READ_LATENCY (LAT),
         .POLL_INTERVAL(16)
      ) u_dut (
         .CLK             (clk),
         .RST_N           (rst_g),
         .CTL_BRAM_ADDR   (addr[g]),
         .CTL_BRAM_EN     (en[g]),
         .CTL_BRAM_DOUT   (dout[g]),
         .MEM_WR_SEGMENT  (mws_o[g]),
         .REQ_RD_SEGMENT  (rrs_o[g]),
         .CYCLE0          (c0_o[g]),
         .CYCLE1          (c1_o[g]),
         .FREQ_DIV0       (fd0_o[g]),
         .FREQ_DIV1       (fd1_o[g]),
         .REP0            (r0_o[g]),
         .REP1            (r1_o[g]),
         .TRANSITION_MODE (tm_o[g]),
         .TRANSITION_VALUE(tv_o[g]),
         .UPDATE          (upd_o[g]),
         .BUSY            (busy_o[g])
      );
   end

   function automatic bundle_t mkb(
      logic mws, logic rrs, logic [15:0] c0, logic [15:0] c1,
      logic [31:0] fd0, logic [31:0] fd1, logic [31:0] r0,
      logic [31:0] r1, logic [7:0] tm, logic [63:0] tv);
      bundle_t b;
      b.mws = mws; b.rrs = rrs; b.c0 = c0; b.c1 = c1;
      b.fd0 = fd0; b.fd1 = fd1; b.r0 = r0; b.r1 = r1;
      b.tm = tm; b.tv = tv;
      return b;
   endfunction

   function automatic bundle_t get_b(int i);
      return mkb(mws_o[i], rrs_o[i], c0_o[i], c1_o[i], fd0_o[i],
                 fd1_o[i], r0_o[i], r1_o[i], tm_o[i], tv_o[i]);
   endfunction

   function automatic logic rst_of(int i);
      return (i == 0) ? rst_n : rst_x;
   endfunction

   function automatic int lat_of(int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: reset values, stability between updates, bundle and latency
   always @(negedge clk) begin
      bundle_t a;
      bundle_t e;
      for (int i = 0; i < 3; i++) begin
         a = get_b(i);
         if (!rst_of(i)) begin
            iss[i] = -1;
            cur[i] = rst_b;
            n_cmp++;
            if (a !== rst_b || upd_o[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL reset_vals[%0d]: got %h upd %b want %h upd 0",
                        i, a, upd_o[i], rst_b);
            end
         end else begin
            if (en[i] && addr[i] == 8'h20) iss[i] = cyc;
            if (upd_o[i]) begin
               upd_cnt[i]++;
               if (expq[i].size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_update[%0d]: got UPDATE=1 want 0", i);
                  cur[i] = a;
               end else begin
                  e = expq[i].pop_front();
                  n_cmp++;
                  if (a !== e) begin
                     n_fail++;
                     $display("FAIL bundle[%0d]: got %h want %h", i, a, e);
                  end
                  n_cmp++;
                  if (cyc - iss[i] != lat_of(i) + 17) begin
                     n_fail++;
                     $display("FAIL latency[%0d]: got %0d want %0d",
                              i, cyc - iss[i], lat_of(i) + 17);
                  end
                  cur[i] = e;
               end
            end else begin
               n_cmp++;
               if (a !== cur[i]) begin
                  n_fail++;
                  $display("FAIL hold[%0d]: got %h want %h", i, a, cur[i]);
                  cur[i] = a;
               end
            end
         end
      end
   end

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_q(int budget);
      int n = 0;
      while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0
             && n < budget) begin
         step(1);
         n++;
      end
      chk("wait_update_pending", 64'(expq[0].size() + expq[1].size()
          + expq[2].size()), 64'd0);
   endtask

   task automatic find_addr(string name, logic [7:0] a);
      int n = 0;
      while (!(en[0] && addr[0] == a) && n < 200) begin
         step(1);
         n++;
      end
      chk(name, 64'(n < 200), 64'd1);
   endtask

   initial begin
      int polls;
      int bad;
      int u;
      bundle_t b2, b3, b4, b5;
      rst_b = mkb(1'b0, 1'b0, 16'h0, 16'h0, 32'h0, 32'h0,
                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h0, 64'h0);
      for (int i = 0; i < 3; i++) begin
         cur[i] = rst_b;
         iss[i] = -1;
         upd_cnt[i] = 0;
      end
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
      step(3);
      rst_n = 1'b1;
      rst_x = 1'b1;

      // idle polling with the flag low
      polls = 0;
      bad = 0;
      repeat (200) begin
         step(1);
         if (en[0]) begin
            polls++;
            if (addr[0] != 8'h00) bad++;
         end
         if (busy_o[0]) bad++;
      end
      chk("idle_polls", 64'(polls), 64'd10);
      chk("idle_addr_busy", 64'(bad), 64'd0);
      chk("idle_no_update", 64'(upd_cnt[0]), 64'd0);
      chk("idle_rep0", 64'(r0_o[0]), 64'hFFFF_FFFF);

      // first load, all three latencies
      mem[8'h22] = 16'h00FF;
      mem[8'h23] = 16'h1234;
      mem[8'h24] = 16'h0001;
      mem[8'h2C] = 16'h0001;
      mem[8'h2D] = 16'h1111;
      mem[8'h2E] = 16'h2222;
      mem[8'h2F] = 16'h3333;
      mem[8'h30] = 16'h4444;
      b2 = mkb(1'b0, 1'b0, 16'h00FF, 16'h0000, 32'h0001_1234, 32'h0,
               32'h0, 32'h0, 8'h01, 64'h4444_3333_2222_1111);
      for (int i = 0; i < 3; i++) expq[i].push_back(b2);
      mem[8'h00] = 16'h0002;
      wait_q(300);
      step(1);
      chk("lat1_one_update", 64'(upd_cnt[1]), 64'd1);
      chk("lat4_one_update", 64'(upd_cnt[2]), 64'd1);
      rst_x = 1'b0;

      // flag held high: no further loads
      u = upd_cnt[0];
      step(1000);
      chk("held_flag_one_load", 64'(upd_cnt[0]), 64'(u));

      // clear then set again: second load with new data
      mem[8'h00] = 16'h0000;
      step(60);
      mem[8'h20] = 16'h0003;
      mem[8'h21] = 16'hFFFE;
      mem[8'h25] = 16'hBEEF;
      mem[8'h26] = 16'h5678;
      mem[8'h27] = 16'h9ABC;
      mem[8'h2C] = 16'h01A5;
      b3 = mkb(1'b1, 1'b0, 16'h00FF, 16'hBEEF, 32'h0001_1234,
               32'h9ABC_5678, 32'h0, 32'h0, 8'hA5, 64'h4444_3333_2222_1111);
      expq[0].push_back(b3);
      mem[8'h00] = 16'h0002;
      wait_q(200);
      chk("rearm_second_load", 64'(upd_cnt[0]), 64'(u + 1));

      // memory changes after 0x28 was read do not leak in
      mem[8'h00] = 16'h0000;
      step(60);
      mem[8'h28] = 16'h0005;
      mem[8'h21] = 16'h0001;
      b4 = mkb(1'b1, 1'b1, 16'h00FF, 16'hBEEF, 32'h0001_1234,
               32'h9ABC_5678, 32'h0000_0005, 32'h0, 8'hA5,
               64'h4444_3333_2222_1111);
      expq[0].push_back(b4);
      mem[8'h00] = 16'h0002;
      find_addr("found_addr_28", 8'h28);
      step(1);
      mem[8'h28] = 16'h0006;
      wait_q(200);

      // reset in the middle of a load, then a fresh load
      mem[8'h00] = 16'h0000;
      step(60);
      mem[8'h2A] = 16'h7777;
      mem[8'h2B] = 16'h8888;
      mem[8'h00] = 16'h0002;
      find_addr("found_addr_25", 8'h25);
      step(1);
      u = upd_cnt[0];
      rst_n = 1'b0;
      step(3);
      chk("midload_rst_rep1", 64'(r1_o[0]), 64'hFFFF_FFFF);
      chk("midload_rst_cycle0", 64'(c0_o[0]), 64'h0);
      chk("midload_rst_en", 64'(en[0]), 64'h0);
      rst_n = 1'b1;
      step(2);
      chk("midload_no_update", 64'(upd_cnt[0]), 64'(u));
      b5 = mkb(1'b1, 1'b1, 16'h00FF, 16'hBEEF, 32'h0001_1234,
               32'h9ABC_5678, 32'h0000_0006, 32'h8888_7777, 8'hA5,
               64'h4444_3333_2222_1111);
      expq[0].push_back(b5);
      wait_q(200);
      chk("post_rst_reload", 64'(upd_cnt[0]), 64'(u + 1));

      step(40);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_settings_loader.md
Name: mod_settings_loader

Overview:
- Polls the controller BRAM.
- On a 0→1 transition of CTL_FLAG bit CTL_FLAG_BIT_MOD_SET, burst-reads the modulation register block (0x20–0x30), assembles a consistent settings bundle and presents it to the modulation engine with a one-cycle UPDATE strobe.
- Sits between the controller BRAM read port and the modulation timing/segment-swap logic.

Parameters:
- READ_LATENCY, 2, cycles from CTL_BRAM_ADDR valid to CTL_BRAM_DOUT valid (1..4).
- POLL_INTERVAL, 16, idle cycles between CTL_FLAG reads (≥1).

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- CTL_BRAM_ADDR  out  8  controller BRAM read address.
- CTL_BRAM_EN  out  1  read enable.
- CTL_BRAM_DOUT  in  16  read data.
- MEM_WR_SEGMENT  out  1  modulation write segment (reg 0x20 bit0).
- REQ_RD_SEGMENT  out  1  requested read segment (reg 0x21 bit0).
- CYCLE0, CYCLE1  out  16  each, from 0x22 / 0x25.
- FREQ_DIV0, FREQ_DIV1  out  32  each, {0x24,0x23} / {0x27,0x26}.
- REP0, REP1  out  32  each, {0x29,0x28} / {0x2B,0x2A}.
- TRANSITION_MODE  out  8  reg 0x2C bits[7:0].
- TRANSITION_VALUE  out  64  {0x30,0x2F,0x2E,0x2D}.
- UPDATE  out  1  one-cycle strobe; all settings outputs are new from this cycle.
- BUSY  out  1  high from the first register read issued until UPDATE.

Behaviour:
- Reset (async assert, sync release):
  - All settings outputs 0, except REP0 = REP1 = 32'hFFFF_FFFF.
  - UPDATE = 0, BUSY = 0, CTL_BRAM_EN = 0, CTL_BRAM_ADDR = 0.
  - Previous-flag register = 0. State = WAIT.
- States:
  - WAIT: counts POLL_INTERVAL cycles → FLAG_REQ.
  - FLAG_REQ: issues address 0x00 with EN = 1 for one cycle → FLAG_WAIT.
  - FLAG_WAIT: waits READ_LATENCY cycles, samples DOUT bit1 → CHECK.
  - CHECK: if sampled = 1 and previous = 0 → LOAD, otherwise → WAIT. Previous-flag is updated with the sampled value on every CHECK.
  - LOAD: issues addresses 0x20..0x30 on 17 consecutive cycles with EN = 1. Each issued address is delayed through a READ_LATENCY-deep index pipeline, and the returned word is written into a shadow register selected by that index.
  - DRAIN: after the last issue, waits until the 0x30 word is captured. The cycle after capture, all shadows copy to the outputs simultaneously and UPDATE = 1 for that cycle → WAIT.
- Word assembly: low 16 bits from the lower address. Bits above a field's width are ignored (0x20, 0x21 use bit0; 0x2C uses [7:0]).
- Latency: UPDATE asserts exactly READ_LATENCY + 17 cycles after the first LOAD issue cycle.
- Outputs never show a partially loaded bundle; they change only on the UPDATE cycle.
- Flag changes during LOAD/DRAIN are not observed. Only the next CHECK sample is evaluated against the previous-flag value latched at the last CHECK.
  - A 1→0→1 pulse entirely within a load is therefore missed by design. The CPU must hold the bit for ≥ POLL_INTERVAL + READ_LATENCY + 20 cycles.
- Flag held at 1: exactly one load. A new load requires a 0 sample first.
- Reset mid-LOAD: shadows are discarded, outputs return to reset values, no UPDATE.
- CTL_BRAM_EN is low in every cycle that does not issue a read.

Test Plan:
- Reset release with the flag at 0 for 200 cycles → UPDATE never asserts; REP0 = 32'hFFFF_FFFF; CTL_BRAM_ADDR toggles only between 0x00 polls.
- Preload 0x22 = 0x00FF, 0x23 = 0x1234, 0x24 = 0x0001, 0x2C = 0x0001, 0x2D..0x30 = 0x1111, 0x2222, 0x3333, 0x4444; set the flag → one UPDATE with CYCLE0 = 0x00FF, FREQ_DIV0 = 0x0001_1234, TRANSITION_MODE = 0x01, TRANSITION_VALUE = 0x4444_3333_2222_1111. UPDATE occurs 19 cycles after the 0x20 issue (READ_LATENCY = 2).
- Flag held at 1 for 1000 cycles → exactly one UPDATE. Clear, then set again → a second UPDATE.
- Change 0x28 from 0x0005 to 0x0006 on the cycle after 0x28 is read → REP0 low half = 0x0005; outputs unchanged until UPDATE.
- Assert RST_N low during LOAD (after 0x25 issued) → outputs at reset values, no UPDATE; after release with the flag still 1 → a fresh full load and UPDATE.
- Rerun scenario 2 with READ_LATENCY = 1 and READ_LATENCY = 4 → identical outputs; UPDATE at 18 and 21 cycles after the first issue.
